// File: rtl/tdm_dac_tx.sv
// tdm_dac_tx
// Latches four signed W-bit channel samples on each rising edge of sample_clk
// and serializes them MSB-first as one 4-slot TDM frame. Each slot is
// SLOT_BITS wide, with the sample left-justified and zero padded. The block
// generates its own bit clock and a one-bit-period frame sync.
//
// Ports:
//   clk            system clock; all logic runs on its rising edge
//   rst            synchronous, active-high reset
//   sample_clk     sample-rate level signal; its rising edge starts a frame
//   sample_in0..3  signed channel samples for slots 0..3
//   bclk           generated bit clock; the receiver samples sdout on its rise
//   fsync          high for the first bit period of slot 0
//   sdout          serial data, MSB first
//   busy           high while a frame is being shifted
//   overrun        sticky; set by a sample_clk edge that arrives while busy
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | outputs low, waiting for a sample_clk rising edge
// ST_SHIFT | shifting a frame out of the shadow registers
module tdm_dac_tx #(
  parameter int W         = 16,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic signed [W-1:0] sample_in0,
  input  logic signed [W-1:0] sample_in1,
  input  logic signed [W-1:0] sample_in2,
  input  logic signed [W-1:0] sample_in3,
  output logic                bclk,
  output logic                fsync,
  output logic                sdout,
  output logic                busy,
  output logic                overrun
);

  localparam int PW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam int DW = $clog2(2 * BCLK_DIV);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t          state_q, state_d;
  logic            sc_prev_q, sc_prev_d;
  logic [W-1:0]    shadow_q [4];
  logic [W-1:0]    shadow_d [4];
  logic [1:0]      slot_q, slot_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [DW-1:0]   phase_q, phase_d;
  logic            bclk_q, bclk_d;
  logic            fsync_q, fsync_d;
  logic            sdout_q, sdout_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;

  logic            start;
  logic            last_phase;
  logic [IW-1:0]   bidx;

  always_comb begin
    state_d    = state_q;
    sc_prev_d  = sample_clk;
    shadow_d   = shadow_q;
    slot_d     = slot_q;
    pos_d      = pos_q;
    phase_d    = phase_q;
    bclk_d     = bclk_q;
    fsync_d    = fsync_q;
    sdout_d    = sdout_q;
    busy_d     = busy_q;
    overrun_d  = overrun_q;
    bidx       = '0;
    start      = sample_clk & ~sc_prev_q;
    last_phase = (int'(phase_q) == 2 * BCLK_DIV - 1);

    case (state_q)
      ST_IDLE: begin
        bclk_d  = 1'b0;
        fsync_d = 1'b0;
        sdout_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          shadow_d[0] = sample_in0;
          shadow_d[1] = sample_in1;
          shadow_d[2] = sample_in2;
          shadow_d[3] = sample_in3;
          slot_d      = '0;
          pos_d       = '0;
          phase_d     = '0;
          state_d     = ST_SHIFT;
          busy_d      = 1'b1;
          fsync_d     = 1'b1;
          sdout_d     = sample_in0[W-1];
        end
      end

      ST_SHIFT: begin
        // Edges during a frame are dropped but remembered as an overrun.
        if (start) overrun_d = 1'b1;
        if (last_phase) begin
          phase_d = '0;
          bclk_d  = 1'b0;
          fsync_d = 1'b0;
          if (int'(pos_q) == SLOT_BITS - 1) begin
            pos_d = '0;
            if (slot_q == 2'd3) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              slot_d = slot_q + 2'd1;
            end
          end else begin
            pos_d = pos_q + 1'b1;
          end
          // Next bit is chosen from the next slot/position; padding past W is 0.
          bidx = IW'(W - 1 - int'(pos_d));
          if (state_d == ST_IDLE || int'(pos_d) >= W) sdout_d = 1'b0;
          else                                        sdout_d = shadow_q[slot_d][bidx];
        end else begin
          phase_d = phase_q + 1'b1;
          bclk_d  = (int'(phase_d) >= BCLK_DIV);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sc_prev_q <= 1'b0;
      for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
      slot_q    <= '0;
      pos_q     <= '0;
      phase_q   <= '0;
      bclk_q    <= 1'b0;
      fsync_q   <= 1'b0;
      sdout_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sc_prev_q <= sc_prev_d;
      shadow_q  <= shadow_d;
      slot_q    <= slot_d;
      pos_q     <= pos_d;
      phase_q   <= phase_d;
      bclk_q    <= bclk_d;
      fsync_q   <= fsync_d;
      sdout_q   <= sdout_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign bclk    = bclk_q;
  assign fsync   = fsync_q;
  assign sdout   = sdout_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_tdm_dac_tx.sv
// Bench for tdm_dac_tx. Two instances share the stimulus: one with default
// parameters (32-bit slots, BCLK_DIV=2) and one with 16-bit slots and
// BCLK_DIV=1 (no padding bits). A frame-time reference model predicts every
// output on every cycle; the directed frame is also reassembled from bclk
// rising edges and compared against constant slot words.
module tb_tdm_dac_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sc;
  logic [15:0] s0, s1, s2, s3;

  logic bclk_a, fsync_a, sdout_a, busy_a, ovr_a;
  logic bclk_b, fsync_b, sdout_b, busy_b, ovr_b;

  int n_assert = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // reference model state, index 0 = default instance, 1 = short-slot instance
  int          p_s [2] = '{32, 16};
  int          p_d [2] = '{2, 1};
  bit          m_act  [2];
  bit          m_prev [2];
  bit          m_ovr  [2];
  int          m_t    [2];
  logic [15:0] m_sh   [2][4];

  bit   capturing = 1'b0;
  logic bclk_a_prev = 1'b0;
  bit   cap [$];

  string nm [5] = '{"bclk", "fsync", "sdout", "busy", "overrun"};

  always #5 clk = ~clk;

  tdm_dac_tx dut_a (
    .clk(clk), .rst(rst), .sample_clk(sc),
    .sample_in0(s0), .sample_in1(s1), .sample_in2(s2), .sample_in3(s3),
    .bclk(bclk_a), .fsync(fsync_a), .sdout(sdout_a), .busy(busy_a), .overrun(ovr_a)
  );

  tdm_dac_tx #(.W(16), .SLOT_BITS(16), .BCLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .sample_clk(sc),
    .sample_in0(s0), .sample_in1(s1), .sample_in2(s2), .sample_in3(s3),
    .bclk(bclk_b), .fsync(fsync_b), .sdout(sdout_b), .busy(busy_b), .overrun(ovr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cycle, obs, exp);
    end
  endtask

  // Expected {bclk, fsync, sdout, busy, overrun} from frame time t.
  function automatic logic [4:0] expect_out(input int i);
    int k, ph, slot, p;
    logic [15:0] w;
    logic b, f, d;
    if (!m_act[i]) return {4'b0000, m_ovr[i]};
    k    = m_t[i] / (2 * p_d[i]);
    ph   = m_t[i] % (2 * p_d[i]);
    slot = k / p_s[i];
    p    = k % p_s[i];
    w    = m_sh[i][slot];
    b    = (ph >= p_d[i]);
    f    = (k == 0);
    d    = (p < 16) ? w[4'(15 - p)] : 1'b0;
    return {b, f, d, 1'b1, m_ovr[i]};
  endfunction

  task automatic model_step(input int i);
    bit st;
    int fl;
    fl = 8 * p_s[i] * p_d[i];
    if (rst) begin
      m_act[i] = 0; m_t[i] = 0; m_prev[i] = 0; m_ovr[i] = 0;
      for (int j = 0; j < 4; j++) m_sh[i][j] = '0;
    end else begin
      st = sc && !m_prev[i];
      if (m_act[i]) begin
        if (st) m_ovr[i] = 1;
        if (m_t[i] == fl - 1) m_act[i] = 0;
        else                  m_t[i]++;
      end else if (st) begin
        m_act[i] = 1; m_t[i] = 0;
        m_sh[i][0] = s0; m_sh[i][1] = s1; m_sh[i][2] = s2; m_sh[i][3] = s3;
      end
      m_prev[i] = sc;
    end
  endtask

  // One clock: model consumes the inputs present at the edge, then outputs are compared.
  task automatic cyc();
    logic [4:0] ea, eb, oa, ob;
    @(posedge clk);
    #1;
    cycle++;
    model_step(0);
    model_step(1);
    ea = expect_out(0);
    eb = expect_out(1);
    oa = {bclk_a, fsync_a, sdout_a, busy_a, ovr_a};
    ob = {bclk_b, fsync_b, sdout_b, busy_b, ovr_b};
    for (int j = 0; j < 5; j++) begin
      chk({"a_", nm[j]}, 32'(oa[4-j]), 32'(ea[4-j]));
      chk({"b_", nm[j]}, 32'(ob[4-j]), 32'(eb[4-j]));
    end
    if (capturing && bclk_a && !bclk_a_prev) cap.push_back(sdout_a);
    bclk_a_prev = bclk_a;
  endtask

  task automatic rand_samples();
    s0 = 16'($urandom); s1 = 16'($urandom); s2 = 16'($urandom); s3 = 16'($urandom);
  endtask

  initial begin
    logic [31:0] exp_w [4];
    logic [31:0] wd;
    int gap, hi;
    exp_w = '{32'h80010000, 32'h7FFE0000, 32'h00000000, 32'hFFFF0000};

    // reset with sample_clk toggling
    rst = 1'b1; sc = 1'b0; rand_samples();
    for (int i = 0; i < 3; i++) begin
      sc = ~sc;
      cyc();
    end
    rst = 1'b0; sc = 1'b0;
    cyc(); cyc();

    // directed frame, inputs change to 0x1234 mid-frame
    s0 = 16'h8001; s1 = 16'h7FFE; s2 = 16'h0000; s3 = 16'hFFFF;
    cap.delete();
    capturing = 1'b1;
    sc = 1'b1;
    for (int i = 0; i < 520; i++) begin
      if (i == 20) sc = 1'b0;
      if (i == 100) begin s0 = 16'h1234; s1 = 16'h1234; s2 = 16'h1234; s3 = 16'h1234; end
      cyc();
    end
    capturing = 1'b0;
    chk("cap_len", 32'(cap.size()), 32'd128);
    if (cap.size() == 128) begin
      for (int j = 0; j < 4; j++) begin
        wd = '0;
        for (int b = 0; b < 32; b++) wd = {wd[30:0], logic'(cap[32 * j + b])};
        chk($sformatf("slot%0d_word", j), wd, exp_w[j]);
      end
    end

    // overrun: second edge 200 cycles into the frame
    rand_samples();
    sc = 1'b1;
    for (int i = 0; i < 530; i++) begin
      if (i == 50)  sc = 1'b0;
      if (i == 200) sc = 1'b1;
      if (i == 260) sc = 1'b0;
      cyc();
    end
    chk("overrun_sticky", 32'(ovr_a), 32'd1);
    // next edge after idle gives a normal frame, overrun stays set
    rand_samples();
    sc = 1'b1;
    for (int i = 0; i < 530; i++) begin
      if (i == 30) sc = 1'b0;
      cyc();
    end

    // reset mid-frame; sample_clk high through reset counts as a fresh edge
    rand_samples();
    sc = 1'b1;
    for (int i = 0; i < 300; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rand_samples();
    for (int i = 0; i < 530; i++) begin
      if (i == 40) sc = 1'b0;
      cyc();
    end

    // held level: exactly one frame, no overrun
    rand_samples();
    sc = 1'b1;
    for (int i = 0; i < 2000; i++) cyc();
    sc = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("held_no_overrun", 32'(ovr_a), 32'd0);

    // random frames, samples scrambled every cycle
    for (int f = 0; f < 8; f++) begin
      gap = int'($urandom_range(700, 100));
      hi  = int'($urandom_range(gap - 1, 1));
      sc  = 1'b1;
      for (int i = 0; i < gap; i++) begin
        if (i == hi) sc = 1'b0;
        rand_samples();
        cyc();
      end
    end
    sc = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rand_samples();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_dac_tx.md
# tdm_dac_tx

Sample-domain TDM serializer; the transmit end of the per-sample core interface. Latches four signed W-bit channel samples on each rising edge of `sample_clk` and shifts them out MSB-first as one 4-slot TDM frame with its own bit clock and frame sync. It sits downstream of audio cores (filter, VCA, etc.) to feed a DAC or a second board's TDM input.

## Interface
- `W`, 16, sample width in bits (two's complement)
- `SLOT_BITS`, 32, bits per TDM slot; must satisfy `SLOT_BITS >= W`
- `BCLK_DIV`, 2, `clk` cycles per bclk half-period; must be >= 1

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `sample_clk`  in  1  sample-rate level signal, synchronous to `clk`; rising edge starts a frame
- `sample_in0`..`sample_in3`  in  W each  signed channel samples, slots 0..3
- `bclk`  out  1  generated bit clock; receiver samples `sdout` on its rising edge
- `fsync`  out  1  frame sync; high for the first bit period of slot 0
- `sdout`  out  1  serial data, MSB first
- `busy`  out  1  high while a frame is being shifted
- `overrun`  out  1  sticky; set when a `sample_clk` edge arrives while busy

## Operation
- Edge detect: register `sample_clk` into `sc_prev`; `start = sample_clk & ~sc_prev`. A level held high never retriggers.
- States: IDLE, SHIFT.
- IDLE: `bclk`=0, `fsync`=0, `sdout`=0, `busy`=0. On `start`: load 4 shadow registers from `sample_in0..3`, bit index = 0, phase counter = 0, go SHIFT.
- SHIFT: frame = 4*SLOT_BITS bits. Bit k belongs to slot k/SLOT_BITS, position p = k mod SLOT_BITS. Bit value = shadow[slot][W-1-p] for p < W, else 0 (sample left-justified, zero pad).
- Each bit period = 2*BCLK_DIV clk cycles: `bclk` low for first BCLK_DIV cycles, high for next BCLK_DIV. `sdout` and `fsync` change only at bit-period boundaries (bclk falling edge), stable around the rising edge.
- `fsync` = 1 during bit 0 only, 0 otherwise.
- After the high phase of bit 4*SLOT_BITS-1: return IDLE.
- `start` while in SHIFT (including the frame's last cycle): edge dropped, shadow unchanged, frame continues, `overrun` set to 1. Cleared only by `rst`.
- Inputs `sample_in*` may change freely during SHIFT; only the shadow copy is transmitted.
- `rst`: state IDLE, `sc_prev`=0, shadows=0, counters=0, all outputs 0 (`bclk`, `fsync`, `sdout`, `busy`, `overrun`). Reset mid-frame aborts immediately; next frame requires a fresh rising edge after reset deasserts (`sc_prev` reset to 0, so `sample_clk` already high in the first post-reset cycle counts as an edge).

## Timing
- `start` seen in cycle n -> in cycle n+1: `busy`=1, `fsync`=1, `bclk`=0, `sdout`=shadow0[W-1].
- `bclk` rises at cycle n+1+BCLK_DIV; bit 1 presented at n+1+2*BCLK_DIV.
- Frame length: 8*SLOT_BITS*BCLK_DIV cycles (512 at defaults); `busy` high for cycles n+1..n+512, low at n+513.
- Earliest next accepted edge: `start` in cycle n+513.
- Outputs are all registered; no combinational path from inputs to outputs.
- Sample rate constraint: sample_clk period must exceed 8*SLOT_BITS*BCLK_DIV cycles, else `overrun`.

## Test plan
- Reset: hold `rst` 3 cycles with `sample_clk` toggling -> all outputs 0, `busy`=0, no bclk activity.
- Single frame, defaults, inputs 0x8001, 0x7FFE, 0x0000, 0xFFFF -> captured serial stream on bclk rising edges = 0x80010000, 0x7FFE0000, 0x00000000, 0xFFFF0000; `fsync` high exactly cycles n+1..n+4; `busy` low at n+513.
- Input change mid-frame: change all `sample_in*` to 0x1234 at cycle n+100 -> transmitted frame unchanged from shadow.
- Overrun: second rising edge at n+200 -> frame completes unchanged, `overrun`=1 from n+201 and stays 1; no second frame started; next edge after idle starts a normal frame with `overrun` still 1.
- Held level: `sample_clk` high for 2000 cycles -> exactly one frame, `overrun`=0.
- Reset mid-frame at n+300 -> outputs 0 next cycle, `overrun` cleared; fresh edge after reset produces full correct frame; also W=16, SLOT_BITS=16, BCLK_DIV=1 -> frame 128 cycles, no padding bits.
